// File: rtl/riscv_configs.sv
// Shared fetch-stage constants: next-PC select encodings, reset vector, NOP and FSM states.
package riscv_configs;

  localparam logic [1:0]  SRC_PC_PC_4      = 2'd0;
  localparam logic [1:0]  SRC_PC_PC_IMM    = 2'd1;
  localparam logic [1:0]  SRC_PC_RS_IMM    = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/riscv_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface riscv_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/riscv_fetch_npc.sv
// Combinational next-PC computation for the retiring instruction.
module riscv_fetch_npc
  import riscv_configs::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_src_pc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1,
  output logic [31:0] o_npc,
  output logic        o_misaligned
);

  logic [31:0] rs_sum;

  // Select the target; jalr-style targets drop bit 0, unknown selects fall through to PC+4.
  always_comb begin
    rs_sum = i_rs1 + i_imm;
    o_npc  = i_pc + 32'd4;
    case (i_src_pc)
      SRC_PC_PC_IMM: o_npc = i_pc + i_imm;
      SRC_PC_RS_IMM: o_npc = {rs_sum[31:1], 1'b0};
      default:       o_npc = i_pc + 32'd4;
    endcase
    o_misaligned = o_npc[1];
  end

endmodule

// File: rtl/riscv_fetch.sv
// Fetch stage: issues one word fetch, holds the instruction for the core, steers the PC.
module riscv_fetch
  import riscv_configs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  riscv_fetch_if.master        imem,
  output logic                 o_if_valid,
  output logic [31:0]          o_if_instr,
  output logic [31:0]          o_if_pc,
  output logic [31:0]          o_if_pc4,
  input  logic                 i_if_ready,
  input  logic [1:0]           i_src_pc,
  input  logic [31:0]          i_imm,
  input  logic [31:0]          i_rs1,
  output logic                 o_fetch_err,
  output logic [31:0]          o_instret
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic [31:0]  instret;
  logic         fetch_err;
  logic [31:0]  npc;
  logic         npc_misaligned;

  riscv_fetch_npc u_npc (
    .i_pc         (pc),
    .i_src_pc     (i_src_pc),
    .i_imm        (i_imm),
    .i_rs1        (i_rs1),
    .o_npc        (npc),
    .o_misaligned (npc_misaligned)
  );

  // Fetch sequencing, PC update, sticky fault flag and retire counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      instr     <= NOP_INSTR;
      fetch_err <= 1'b0;
      instret   <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (imem.imem_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.imem_rvalid) begin
            instr <= imem.imem_rdata;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_if_ready) begin
            instret <= instret + 32'd1;
            if (npc_misaligned) begin
              fetch_err <= 1'b1;
              state     <= ST_HALT;
            end else begin
              pc    <= npc;
              state <= ST_REQ;
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode directly from state and the held registers.
  always_comb begin
    imem.imem_req  = (state == ST_REQ);
    imem.imem_addr = pc;
    o_if_valid     = (state == ST_HOLD);
    o_if_instr     = instr;
    o_if_pc        = pc;
    o_if_pc4       = pc + 32'd4;
    o_fetch_err    = fetch_err;
    o_instret      = instret;
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Randomized scoreboard bench for riscv_fetch with a directed opening sequence.
module tb_riscv_fetch;
  import riscv_configs::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } fetch_t;
  typedef struct { logic [1:0] src; logic [31:0] imm; logic [31:0] rs1; } retire_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready, fetch_err;
  logic [31:0] if_instr, if_pc, if_pc4, instret, imm, rs1;
  logic [1:0]  src_pc;

  riscv_fetch_if imem();

  riscv_fetch #(.RESET_PC(RST_PC)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .imem        (imem),
    .o_if_valid  (if_valid),
    .o_if_instr  (if_instr),
    .o_if_pc     (if_pc),
    .o_if_pc4    (if_pc4),
    .i_if_ready  (if_ready),
    .i_src_pc    (src_pc),
    .i_imm       (imm),
    .i_rs1       (rs1),
    .o_fetch_err (fetch_err),
    .o_instret   (instret)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference-model state.
  fetch_t      exp_q[$];
  retire_t     script_q[$];
  int unsigned n_cmp = 0, n_fail = 0;
  logic [31:0] cur_pc, pend_addr, retires;
  bit          halted, pending, fast, stray_en;
  int          ready_mode, delay_fix, retire_pct, pend_cnt, hcnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    fetch_t f;
    f.pc = a;
    f.instr = mem_word(a);
    exp_q.push_back(f);
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    rst = 1'b1; if_ready = 1'b0;
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0;
    pending = 0; halted = 0; retires = '0;
    exp_q.delete(); cur_pc = RST_PC; push_fetch(RST_PC);
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_retire(output retire_t r);
    int k;
    k = int'($urandom_range(0, 255)) - 128;
    r.src = 2'($urandom_range(0, 3));
    r.imm = 32'(k * 4);
    r.rs1 = $urandom & 32'hFFFF_FFFD;
    if ($urandom_range(0, 29) == 0)
      r.imm = r.imm | ((r.src == SRC_PC_RS_IMM) ? 32'($urandom_range(1, 3)) : 32'h2);
  endtask

  // One cycle of memory behaviour and core retire decisions, driven on the falling edge.
  task automatic step();
    retire_t     r;
    logic [31:0] npc;
    @(negedge clk);
    if (pending) begin
      if (pend_cnt == 0) begin
        imem.imem_rvalid = 1'b1; imem.imem_rdata = mem_word(pend_addr); pending = 0;
      end else begin
        pend_cnt--; imem.imem_rvalid = 1'b0; imem.imem_rdata = $urandom;
      end
    end else begin
      imem.imem_rvalid = stray_en && ($urandom_range(0, 3) == 0);
      imem.imem_rdata  = $urandom;
    end
    if (imem.imem_req) begin
      if (exp_q.size() == 0) check("unexpected_req", 32'h1, 32'h0);
      else check("imem_addr", imem.imem_addr, exp_q[0].pc);
      case (ready_mode)
        1:       imem.imem_ready = 1'b1;
        2:       imem.imem_ready = 1'b0;
        default: imem.imem_ready = ($urandom_range(0, 99) < 60);
      endcase
      if (imem.imem_ready) begin
        pending = 1; pend_addr = imem.imem_addr;
        pend_cnt = fast ? 0 : (delay_fix >= 0 ? delay_fix : int'($urandom_range(0, 3)));
      end
    end else begin
      imem.imem_ready = 1'($urandom_range(0, 1));
    end
    if_ready = 1'b0;
    src_pc = 2'($urandom); imm = $urandom; rs1 = $urandom;
    if (if_valid && !halted && ($urandom_range(0, 99) < retire_pct)) begin
      if (script_q.size() != 0) r = script_q.pop_front();
      else rand_retire(r);
      src_pc = r.src; imm = r.imm; rs1 = r.rs1; if_ready = 1'b1;
      retires = retires + 32'd1;
      case (r.src)
        SRC_PC_PC_IMM: npc = cur_pc + r.imm;
        SRC_PC_RS_IMM: npc = (r.rs1 + r.imm) & 32'hFFFF_FFFE;
        default:       npc = cur_pc + 32'd4;
      endcase
      if (npc[1]) begin
        halted = 1; hcnt = 0;
      end else begin
        cur_pc = npc; push_fetch(npc);
      end
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard after each rising edge.
  initial begin
    fetch_t      f;
    bit          prev_valid = 0;
    int unsigned cyc = 0, last_rise = 0, stall = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        check("rst_req", 32'(imem.imem_req), 32'h0);
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_instr", if_instr, NOP_INSTR);
        check("rst_pc", if_pc, RST_PC);
        check("rst_err", 32'(fetch_err), 32'h0);
        check("rst_instret", instret, 32'h0);
        prev_valid = 0; cyc = 0; last_rise = 0; stall = 0;
      end else begin
        cyc++;
        check("instret", instret, retires);
        if (halted) begin
          check("halt_err", 32'(fetch_err), 32'h1);
          check("halt_req", 32'(imem.imem_req), 32'h0);
          check("halt_valid", 32'(if_valid), 32'h0);
        end else begin
          check("err_clear", 32'(fetch_err), 32'h0);
          if (if_valid && !prev_valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'h1, 32'h0);
            else begin
              f = exp_q.pop_front();
              check("if_pc", if_pc, f.pc);
              check("if_instr", if_instr, f.instr);
              check("if_pc4", if_pc4, f.pc + 32'd4);
            end
            if (fast) check("issue_interval", cyc - last_rise, 32'd3);
            last_rise = cyc; stall = 0;
          end else if (!if_valid) begin
            stall++;
            if (stall > 150) begin
              check("progress_timeout", stall, 32'd0);
              stall = 0;
            end
          end
        end
        prev_valid = if_valid;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed opening, reset-in-WAIT scenario, then randomized traffic.
  initial begin
    retire_t r;
    int      guard;
    rst = 1'b1; if_ready = 1'b0; src_pc = '0; imm = '0; rs1 = '0;
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    fast = 1; stray_en = 0; ready_mode = 1; delay_fix = -1; retire_pct = 100;
    pending = 0; halted = 0; retires = '0; hcnt = 0;
    cur_pc = RST_PC; push_fetch(RST_PC);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Four sequential retires, a PC-relative branch back, a register jump, then a faulting jump.
    repeat (4) begin r.src = SRC_PC_PC_4; r.imm = $urandom; r.rs1 = $urandom; script_q.push_back(r); end
    r.src = SRC_PC_PC_IMM; r.imm = 32'hFFFF_FFF8; r.rs1 = 32'h0;   script_q.push_back(r);
    r.src = SRC_PC_RS_IMM; r.imm = 32'h3;         r.rs1 = 32'h101; script_q.push_back(r);
    r.src = SRC_PC_RS_IMM; r.imm = 32'h2;         r.rs1 = 32'h100; script_q.push_back(r);
    guard = 0;
    while (!halted && guard < 200) begin step(); guard++; end
    check("directed_halt_reached", 32'(halted), 32'h1);
    check("directed_retires", retires, 32'd7);
    repeat (12) step();

    // Address held while ready is low, then reset lands during an outstanding read.
    fast = 0; stray_en = 1; ready_mode = 2; delay_fix = 20;
    do_reset(2);
    guard = 0;
    begin
      int unsigned low = 0;
      while (low < 5 && guard < 100) begin
        step(); guard++;
        if (imem.imem_req && !imem.imem_ready) low++;
      end
    end
    ready_mode = 1; guard = 0;
    while (!pending && guard < 100) begin step(); guard++; end
    check("wait_entered", 32'(pending), 32'h1);
    repeat (3) step();
    ready_mode = 0; delay_fix = -1;
    do_reset(1);

    // Randomized traffic with sporadic resets and fault recovery.
    retire_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (halted) begin
        hcnt++;
        if (hcnt >= 12) do_reset(1);
        else step();
      end else if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        step();
      end
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 o_imem_req  output  1  instruction-memory address valid.
REQ-005 o_imem_addr  output  32  fetch address, word-aligned.
REQ-006 i_imem_ready  input  1  memory accepts address this cycle.
REQ-007 i_imem_rvalid  input  1  read data valid.
REQ-008 i_imem_rdata  input  32  instruction word.
REQ-009 o_if_valid  output  1  instruction presented to decode/control.
REQ-010 o_if_instr  output  32  held instruction.
REQ-011 o_if_pc  output  32  PC of held instruction.
REQ-012 o_if_pc4  output  32  o_if_pc + 4.
REQ-013 i_if_ready  input  1  core retires presented instruction this cycle.
REQ-014 i_src_pc  input  2  next-PC select from control (SRC_PC_PC_4 / SRC_PC_PC_IMM / SRC_PC_RS_IMM).
REQ-015 i_imm  input  32  sign-extended immediate of presented instruction.
REQ-016 i_rs1  input  32  rs1 value of presented instruction.
REQ-017 o_fetch_err  output  1  sticky misaligned-target flag.
REQ-018 o_instret  output  32  retired-instruction counter.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, HOLD, HALT.
REQ-020 IDLE SHALL go to REQ unconditionally the cycle after reset deasserts.
REQ-021 In REQ, o_imem_req=1 and o_imem_addr=PC; i_imem_ready=1 -> WAIT, else remain in REQ with address stable.
REQ-022 In WAIT, i_imem_rvalid=1 SHALL capture i_imem_rdata into o_if_instr and go to HOLD; rvalid is never accepted in the address-accept cycle.
REQ-023 i_imem_rvalid outside WAIT SHALL be ignored.
REQ-024 In HOLD, o_if_valid=1; o_if_instr/o_if_pc stable until i_if_ready=1.
REQ-025 On HOLD with i_if_ready=1, next PC SHALL be: PC_4 -> PC+4; PC_IMM -> PC+i_imm; RS_IMM -> (i_rs1+i_imm) with bit0 cleared; other select value -> PC+4; all mod 2^32.
REQ-026 If next PC bit1=1, PC SHALL not update, o_fetch_err SHALL set, state -> HALT; else PC updates and state -> REQ.
REQ-027 HALT SHALL hold all outputs (o_imem_req=0, o_if_valid=0) until reset.
REQ-028 o_instret SHALL increment on every HOLD & i_if_ready cycle, including the faulting one; wraps 0xFFFF_FFFF -> 0.
REQ-029 Minimum issue interval SHALL be 3 cycles (REQ, WAIT, HOLD) with ready/rvalid/if_ready asserted at earliest.
REQ-030 o_if_pc4 SHALL be combinational from o_if_pc.

Reset
REQ-031 During i_rst=1: state=IDLE, PC=RESET_PC, o_imem_req=0, o_if_valid=0, o_if_instr=32'h0000_0013 (NOP), o_if_pc=RESET_PC, o_fetch_err=0, o_instret=0.
REQ-032 Reset SHALL take priority in every state, including mid-WAIT; the outstanding request is abandoned and instruction memory is reset in the same cycle.

Structure
REQ-033 SRC_PC_* encodings, RESET_PC default, and NOP encoding SHALL live in riscv_configs.
REQ-034 Next-PC arithmetic SHALL be one combinational sub-module riscv_fetch_npc; FSM, PC, and counters stay in riscv_fetch.

Verification
REQ-035 Reset release, ready=1, rvalid one cycle later with 0x00500093 -> o_if_valid in cycle 3, o_if_pc=0x0, o_if_instr=0x00500093.
REQ-036 Sequential retire with src_pc=PC_4 over 4 instrs -> addresses 0x0, 0x4, 0x8, 0xC; o_instret=4.
REQ-037 PC=0x10, src_pc=PC_IMM, imm=0xFFFFFFF8 -> next o_imem_addr=0x08; src_pc=RS_IMM, rs1=0x101, imm=0x3 -> 0x104.
REQ-038 RS_IMM, rs1=0x100, imm=0x2 -> o_fetch_err=1, HALT, o_imem_req stays 0 for 10 cycles, o_instret incremented.
REQ-039 i_imem_ready low 5 cycles, then i_rst pulsed during WAIT; stray rvalid afterwards -> address stable while ready low, rvalid ignored, restart at RESET_PC.
